// File: rtl/eth_mdio_pkg.sv
// Shared constants, state type and phase-length helper for the Clause-22 MDIO master.
package eth_mdio_pkg;

    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int HDR_BITS  = 14;
    localparam int TA_BITS   = 2;
    localparam int DATA_BITS = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_HEADER   = 3'd2,
        S_TA       = 3'd3,
        S_DATA     = 3'd4,
        S_DONE     = 3'd5
    } mdio_state_e;

    // Index of the last bit of a frame phase; non-frame states return 0.
    function automatic logic [5:0] phase_last(input mdio_state_e s, input int pre_len);
        logic [5:0] r;
        case (s)
            S_PREAMBLE: r = 6'(pre_len - 1);
            S_HEADER:   r = 6'(HDR_BITS - 1);
            S_TA:       r = 6'(TA_BITS - 1);
            S_DATA:     r = 6'(DATA_BITS - 1);
            default:    r = 6'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/eth_mdio_clk_gen.sv
// MDC generator: CLK_DIV cycles low then CLK_DIV cycles high per bit, held low while disabled.
module eth_mdio_clk_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mdc,
    output logic fall_stb,
    output logic rise_stb
);
    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mdc_q, mdc_d;

    // Phase counter and MDC level for the next cycle.
    always_comb begin
        cnt_d = '0;
        mdc_d = 1'b0;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
            mdc_d = (cnt_d >= HALF);
        end else begin
            cnt_d = '0;
            mdc_d = 1'b0;
        end
    end

    // Counter and MDC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    // fall_stb: last cycle of a bit; rise_stb: first cycle with MDC high.
    assign fall_stb = en && (cnt_q == LAST);
    assign rise_stb = en && (cnt_q == HALF);
    assign mdc      = mdc_q;

endmodule

// File: rtl/eth_mdio_master.sv
// Clause-22 MDIO master: one read/write frame per accepted command, one-cycle response.
// Optional macro ETH_MDIO_TA_CHECK_EN adds rsp_err for reads where no PHY drove TA low.
module eth_mdio_master #(
    parameter int CLK_DIV      = 50,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
`ifdef ETH_MDIO_TA_CHECK_EN
    output logic        rsp_err,
`endif
    output logic        eth_mdio_mdc,
    output logic        eth_mdio_mdio_o,
    output logic        eth_mdio_mdio_t,
    input  logic        eth_mdio_mdio_i
);
    import eth_mdio_pkg::*;

    mdio_state_e state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        write_q, write_d;
    logic [31:0] shift_q, shift_d;
    logic [15:0] rd_sh_q, rd_sh_d;
    logic        sync1_q, sync2_q;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_t_q, mdio_t_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
`ifdef ETH_MDIO_TA_CHECK_EN
    logic        ta_bit_q, ta_bit_d;
    logic        rsp_err_q, rsp_err_d;
`endif
    logic        accept_s, busy_s, fall_stb_s, rise_stb_s, mdc_s;

    assign accept_s = cmd_valid && cmd_ready_q;
    assign busy_s   = (state_q != S_IDLE) && (state_q != S_DONE);

    eth_mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (sys_clk),
        .rst_n    (rst_n),
        .en       (busy_s),
        .mdc      (mdc_s),
        .fall_stb (fall_stb_s),
        .rise_stb (rise_stb_s)
    );

    // State register and all datapath flops.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 6'd0;
            write_q     <= 1'b0;
            shift_q     <= 32'd0;
            rd_sh_q     <= 16'd0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            mdio_o_q    <= 1'b1;
            mdio_t_q    <= 1'b1;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'd0;
`ifdef ETH_MDIO_TA_CHECK_EN
            ta_bit_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            write_q     <= write_d;
            shift_q     <= shift_d;
            rd_sh_q     <= rd_sh_d;
            sync1_q     <= eth_mdio_mdio_i;
            sync2_q     <= sync1_q;
            mdio_o_q    <= mdio_o_d;
            mdio_t_q    <= mdio_t_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef ETH_MDIO_TA_CHECK_EN
            ta_bit_q    <= ta_bit_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // Next state: phases advance on the last cycle of their final bit.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d   = S_PREAMBLE;
                    bit_cnt_d = 6'd0;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_PREAMBLE, S_HEADER, S_TA, S_DATA: begin
                if (fall_stb_s) begin
                    if (bit_cnt_q == phase_last(state_q, PREAMBLE_LEN)) begin
                        bit_cnt_d = 6'd0;
                        case (state_q)
                            S_PREAMBLE: state_d = S_HEADER;
                            S_HEADER:   state_d = S_TA;
                            S_TA:       state_d = S_DATA;
                            default:    state_d = S_DONE;
                        endcase
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: line drive per bit, read shifting and response capture.
    always_comb begin
        write_d     = write_q;
        shift_d     = shift_q;
        rd_sh_d     = rd_sh_q;
        mdio_o_d    = mdio_o_q;
        mdio_t_d    = mdio_t_q;
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef ETH_MDIO_TA_CHECK_EN
        ta_bit_d    = ta_bit_q;
        rsp_err_d   = rsp_err_q;
`endif
        if ((state_q == S_IDLE) && accept_s) begin
            // Reads carry 1s in TA/DATA slots so the released line idles high.
            write_d  = cmd_write;
            shift_d  = {ST, cmd_write ? OP_WRITE : OP_READ, cmd_phy_addr, cmd_reg_addr,
                        cmd_write ? TA_WRITE : 2'b11, cmd_write ? cmd_wdata : 16'hFFFF};
            mdio_o_d = 1'b1;
            mdio_t_d = 1'b0;
        end else if (fall_stb_s) begin
            case (state_d)
                S_PREAMBLE: begin
                    mdio_o_d = 1'b1;
                    mdio_t_d = 1'b0;
                end
                S_HEADER: begin
                    mdio_o_d = shift_q[31];
                    mdio_t_d = 1'b0;
                    shift_d  = {shift_q[30:0], 1'b0};
                end
                S_TA, S_DATA: begin
                    mdio_o_d = shift_q[31];
                    mdio_t_d = ~write_q;
                    shift_d  = {shift_q[30:0], 1'b0};
                end
                default: begin
                    mdio_o_d = 1'b1;
                    mdio_t_d = 1'b1;
                end
            endcase
        end else begin
            mdio_o_d = mdio_o_q;
            mdio_t_d = mdio_t_q;
        end

        if (rise_stb_s && (state_q == S_DATA)) begin
            rd_sh_d = {rd_sh_q[14:0], sync2_q};
        end else begin
            rd_sh_d = rd_sh_d;
        end
`ifdef ETH_MDIO_TA_CHECK_EN
        if (rise_stb_s && (state_q == S_TA) && (bit_cnt_q == 6'd1)) begin
            ta_bit_d = sync2_q;
        end else begin
            ta_bit_d = ta_bit_q;
        end
`endif

        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            rsp_valid_d = 1'b1;
`ifdef ETH_MDIO_TA_CHECK_EN
            rsp_err_d   = !write_q && ta_bit_q;
            rsp_rdata_d = write_q ? 16'd0 : (ta_bit_q ? 16'hFFFF : rd_sh_q);
`else
            rsp_rdata_d = write_q ? 16'd0 : rd_sh_q;
`endif
        end else begin
            rsp_valid_d = 1'b0;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
`ifdef ETH_MDIO_TA_CHECK_EN
    assign rsp_err         = rsp_err_q;
`endif
    assign eth_mdio_mdc    = mdc_s;
    assign eth_mdio_mdio_o = mdio_o_q;
    assign eth_mdio_mdio_t = mdio_t_q;

endmodule

// File: doc/eth_mdio_master.md
Name: eth_mdio_master

Overview:
- Clause-22 MDIO management master that generates MDC and the MDIO output/tristate/input triplet feeding the board's MDIO IOBUF (I = eth_mdio_mdio_o, T = eth_mdio_mdio_t, O = eth_mdio_mdio_i).
- Takes single PHY register read/write commands over a valid/ready interface from the CPU-side register block.
- Performs exactly one MDIO frame per command and returns a one-cycle response pulse.

Parameters:
- CLK_DIV, 50, sys_clk cycles per MDC half-period; minimum 4. With a 100 MHz sys_clk this gives MDC = 1 MHz.
- PREAMBLE_LEN, 32, number of preamble '1' bits per frame; legal range 1..32.

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_phy_addr  in  5  PHY address
- cmd_reg_addr  in  5  register address
- cmd_wdata  in  16  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  read data; 0 for writes
- eth_mdio_mdc  out  1  MDC
- eth_mdio_mdio_o  out  1  MDIO output data
- eth_mdio_mdio_t  out  1  tristate control; 1 = released
- eth_mdio_mdio_i  in  1  MDIO input from IOBUF

Behaviour:
- Reset (asynchronous, active-low), values: mdc=0, mdio_o=1, mdio_t=1, cmd_ready=1, rsp_valid=0, rsp_rdata=0. State goes to IDLE, counters clear.
- Command acceptance: on cmd_valid && cmd_ready, latch all cmd_* fields and leave IDLE. cmd_ready drops the next cycle and stays low until back in IDLE.
- Bit timing: each bit lasts 2*CLK_DIV cycles. MDC is low for the first CLK_DIV cycles and high for the second. mdio_o/mdio_t update on the cycle MDC goes low.
- Input sampling: mdio_i passes through a 2-flop synchroniser. The synchronised value is sampled on the cycle MDC goes high.
- Frame length: PREAMBLE_LEN + 32 bits.
- Frame contents, in order:
  - PREAMBLE: all 1s.
  - ST: 01.
  - OP: 01 for write, 10 for read.
  - PHYAD and REGAD: MSB first.
  - TA: write drives 10; read releases the line (t=1) for both bits.
  - DATA: 16 bits, MSB first. Write drives cmd_wdata; read keeps t=1 and shifts sampled bits into rsp_rdata.
- Write frames keep mdio_t=0 from the first preamble bit through the last data bit.
- States and transitions:
  - IDLE: mdc=0, t=1, o=1.
  - PREAMBLE -> HEADER (14 bits) -> TA (2 bits) -> DATA (16 bits) -> DONE -> IDLE.
  - DONE lasts one cycle: rsp_valid=1, t=1, mdc=0.
- Latency: rsp_valid rises exactly (PREAMBLE_LEN+32)*2*CLK_DIV + 1 cycles after the accept cycle.
- rsp_rdata holds its value until the next response.
- A cmd_valid held across DONE is accepted in the IDLE cycle that follows. There are no back-to-back frames without at least 1 IDLE cycle.
- Changes on cmd_* while busy are ignored.
- Reset mid-frame: outputs return to reset values immediately, no rsp_valid is produced, and the partial frame is abandoned.

Optional Feature:
- Macro: ETH_MDIO_TA_CHECK_EN.
- With the macro defined:
  - Extra output rsp_err (1 bit, reset 0).
  - On reads, the second TA bit is sampled; if it is 1 (no PHY responding), rsp_err=1 is reported alongside rsp_valid and rsp_rdata is forced to 16'hFFFF.
  - Writes always report rsp_err=0.
- Without the macro: there is no rsp_err port, and read data is returned as sampled.

Decomposition:
- Package eth_mdio_pkg holds:
  - OP_READ = 2'b10, OP_WRITE = 2'b01, ST = 2'b01
  - header and data bit counts
  - state enum type mdio_state_e
- Sub-module eth_mdio_clk_gen: CLK_DIV counter producing mdc plus one-cycle fall_stb/rise_stb strobes. It is held idle (mdc=0) when its enable is low.
- The main FSM and shift registers stay in eth_mdio_master.

Test Plan (CLK_DIV=4, PREAMBLE_LEN=32):
- Write phy=1 reg=0 data=16'h1140:
  - Bits captured on MDC rising edges are 32 ones, then 01 01 00001 00000 10 0001000101000000.
  - t=0 throughout the frame.
  - rsp_valid arrives 513 cycles after accept, with rsp_rdata=0.
- Read phy=1 reg=2, PHY model drives TA=z,0 and data 16'h2000:
  - t goes to 1 at the start of TA.
  - rsp_rdata=16'h2000 and rsp_valid is a single-cycle pulse.
- cmd_valid held high continuously with two commands:
  - cmd_ready stays low for the whole frame.
  - The second command is accepted exactly 1 cycle after the first rsp_valid.
  - No commands are dropped or duplicated.
- MDC shape:
  - Period is 8 cycles with 4 high / 4 low.
  - In IDLE, mdc=0, t=1, o=1.
- rst_n asserted during the DATA phase of a read:
  - Same cycle: mdc=0, t=1, cmd_ready=1.
  - No rsp_valid afterwards.
  - The next command completes correctly.
- With ETH_MDIO_TA_CHECK_EN, read with no PHY present (line pulled to 1): rsp_err=1 and rsp_rdata=16'hFFFF. Without the macro: rsp_rdata=16'hFFFF.
